mul_arbiter: RTL and testbench

Shares one sequential signed multiplier among NREQ requesters. The block accepts operand pairs over per-requester valid/ready handshakes and arbitrates round-robin, or fixed-priority when compiled without the round-robin option. It sequences the multiplier through start and a fixed-latency wait, then returns the 2*WIDTH-bit product to the granted requester. Only one operation is outstanding at a time; the block sits between the execution-unit clients and the shared multiplier.

---
 rtl/mul_arb_pkg.sv | 17 +
 rtl/mul_arb_pick.sv | 63 ++++++
 rtl/mul_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Holds the FSM state encoding and the default multiplier latency helper.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mul_arb_state_t;

    // Default number of cycles from the start pulse until the product is valid.
    function automatic int mul_arb_default_latency(input int width);
        return 2 * width + 3;
    endfunction

endpackage

// File: rtl/mul_arb_pick.sv
// Combinational request picker for mul_arbiter.
// Build option MUL_ARB_RR_EN: when defined, the search starts at rr_ptr and
// wraps (round-robin); when undefined, the lowest asserted index wins and
// rr_ptr is ignored.
module mul_arb_pick
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

`ifdef MUL_ARB_RR_EN
    int             sum_s;
    logic [IDW-1:0] idx_s;

    // Scan from rr_ptr upward with wrap-around; the first asserted request wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        sum_s     = 0;
        idx_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s = int'(rr_ptr) + i;
            idx_s = (sum_s >= NREQ) ? IDW'(sum_s - NREQ) : IDW'(sum_s);
            if (!any_valid && req_valid[idx_s]) begin
                any_valid        = 1'b1;
                grant_idx        = idx_s;
                grant_oh[idx_s]  = 1'b1;
            end else begin
                // an earlier position in the scan already won
            end
        end
    end
`else
    logic unused_rr_ptr_s;
    assign unused_rr_ptr_s = ^rr_ptr;

    // Scan downward so the lowest asserted index is the one left standing.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid   = 1'b1;
                grant_idx   = IDW'(i);
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
            end else begin
                // keep the previous (higher-index) candidate
            end
        end
    end
`endif

endmodule

// File: rtl/mul_arbiter.sv
// Shares one fixed-latency signed multiplier among NREQ requesters.
// One operation in flight: accept -> start pulse -> wait -> respond.
// Build option MUL_ARB_RR_EN selects round-robin arbitration (with an rr_ptr
// register); without it the picker is fixed-priority, lowest index first.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NREQ        = 4,
    parameter int MUL_LATENCY = mul_arb_default_latency(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    input  logic [WIDTH-1:0]         mul_product_h,
    input  logic [WIDTH-1:0]         mul_product_l
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MUL_LATENCY + 1);

    mul_arb_state_t      state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                mul_start_q, mul_start_d;
    logic                busy_q, busy_d;

    logic [NREQ-1:0]     pick_oh_s;
    logic [IDW-1:0]      pick_idx_s;
    logic                pick_any_s;
    logic [IDW-1:0]      rr_ptr_s;

`ifdef MUL_ARB_RR_EN
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    assign rr_ptr_s = rr_ptr_q;
`else
    assign rr_ptr_s = '0;
`endif

    mul_arb_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_s),
        .grant_oh  (pick_oh_s),
        .grant_idx (pick_idx_s),
        .any_valid (pick_any_s)
    );

    // Accept is offered only while idle, so nothing is taken while a response is pending.
    assign req_ready        = (state_q == ST_IDLE && !rst) ? pick_oh_s : '0;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_product      = result_q;
    assign busy             = busy_q;
    assign grant_id         = grant_q;
    assign mul_start        = mul_start_q;
    assign mul_multiplicand = op_a_q;
    assign mul_multiplier   = op_b_q;

    // Next-state and datapath computation for the accept/issue/wait/respond sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
`ifdef MUL_ARB_RR_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_idx_s;
                    op_a_d  = req_a[pick_idx_s*WIDTH +: WIDTH];
                    op_b_d  = req_b[pick_idx_s*WIDTH +: WIDTH];
`ifdef MUL_ARB_RR_EN
                    rr_ptr_d = (int'(pick_idx_s) + 1 >= NREQ) ? '0 : pick_idx_s + IDW'(1);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CW'(MUL_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    result_d = {mul_product_h, mul_product_l};
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready[grant_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they leave a flop.
        mul_start_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = '0;
        if (state_d == ST_RESP) begin
            rsp_valid_d[grant_d] = 1'b1;
        end else begin
            rsp_valid_d = '0;
        end
    end

    // State and datapath registers; rst returns everything to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            rsp_valid_q <= '0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MUL_ARB_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            rsp_valid_q <= rsp_valid_d;
            mul_start_q <= mul_start_d;
            busy_q      <= busy_d;
`ifdef MUL_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural fixed-latency multiplier.
// Expected grants, products and timing come from a reference model of the
// arbitration rules kept here; honours MUL_ARB_RR_EN like the design.
module tb_mul_arbiter;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int L   = 2 * W + 3;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic [2*W-1:0]   rsp_product;
    logic             busy;
    logic [IDW-1:0]   grant_id;
    logic             mul_start;
    logic [W-1:0]     mul_multiplicand, mul_multiplier, mul_product_h, mul_product_l;

    int n_checks = 0;
    int n_pass   = 0;
    int ref_ptr  = 0;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(W), .NREQ(N), .MUL_LATENCY(L)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_product      (rsp_product),
        .busy             (busy),
        .grant_id         (grant_id),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product_h    (mul_product_h),
        .mul_product_l    (mul_product_l)
    );

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Behavioural multiplier: garbage after start, true product L cycles after the start cycle.
    int             mcnt;
    logic [2*W-1:0] mprod;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt  <= 0;
            mprod <= '0;
        end else if (mul_start) begin
            mcnt  <= L - 1;
            mprod <= 32'hDEAD_BEEF;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mprod <= smul(mul_multiplicand, mul_multiplier);
        end
    end
    assign {mul_product_h, mul_product_l} = mprod;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int expect_grant(input logic [N-1:0] m);
`ifdef MUL_ARB_RR_EN
        for (int k = 0; k < N; k++) if (m[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (m[k]) return k;
`endif
        return -1;
    endfunction

    // One full transaction starting at a negedge; rst_at>0 asserts rst in that cycle.
    task automatic run_op(input logic [N-1:0] vmask, input int hold, input int rst_at);
        int g, cyc, starts, rsp_cyc;
        logic [N-1:0] goh;
        logic [W-1:0] ea, eb;
        logic [2*W-1:0] expp;
        logic hold_ok, stable;
        g = expect_grant(vmask);
        goh = '0;
        goh[g] = 1'b1;
        ea = opa[g];
        eb = opb[g];
        expp = smul(ea, eb);
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
        req_valid = vmask;
        #1;
        check_eq("req_ready", req_ready, goh);
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        req_valid = '0;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        check_eq("issue", {mul_start, busy, grant_id, mul_multiplicand, mul_multiplier},
                 {1'b1, 1'b1, IDW'(g), ea, eb});
        starts = 1;
        rsp_cyc = -1;
        hold_ok = 1'b1;
        while (rsp_cyc < 0 && cyc < L + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check_eq("rst_mid_ctl", {req_ready, rsp_valid, mul_start, busy, grant_id}, '0);
                check_eq("rst_mid_data", {rsp_product, mul_multiplicand, mul_multiplier}, '0);
                @(negedge clk);
                rst = 1'b0;
                ref_ptr = 0;
                return;
            end
            if (mul_start) starts++;
            if (mul_multiplicand !== ea || mul_multiplier !== eb) hold_ok = 1'b0;
            if (rsp_valid != '0) rsp_cyc = cyc;
        end
        check_eq("rsp_cycle", rsp_cyc, L + 2);
        check_eq("start_pulses", starts, 1);
        check_eq("operand_hold", hold_ok, 1'b1);
        check_eq("rsp_valid", rsp_valid, goh);
        check_eq("rsp_product", rsp_product, expp);
        check_eq("rsp_grant", {grant_id, req_ready}, {IDW'(g), {N{1'b0}}});
        // Backpressure: others acknowledge and everyone requests, nothing may move.
        stable = 1'b1;
        rsp_ready = ~goh;
        req_valid = '1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== goh || rsp_product !== expp || req_ready !== '0 ||
                mul_start !== 1'b0 || mul_multiplicand !== ea) stable = 1'b0;
        end
        if (hold > 0) check_eq("bp_stable", stable, 1'b1);
        rsp_ready = goh;
        req_valid = '0;
        @(negedge clk);
        rsp_ready = '0;
        check_eq("back_idle", {busy, rsp_valid}, '0);
`ifdef MUL_ARB_RR_EN
        ref_ptr = (g + 1) % N;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", {req_ready, rsp_valid, mul_start, busy, grant_id}, '0);
        check_eq("reset_data", {rsp_product, mul_multiplicand, mul_multiplier}, '0);
        rst = 1'b0;
        @(negedge clk);

        // All requesters valid together: RR order 0,1,2,3,0 or always 0.
        for (int i = 0; i < N; i++) begin
            opa[i] = W'(i + 1);
            opb[i] = W'(100 + i);
        end
        repeat (5) run_op(4'hF, 0, 0);

        // Directed single request and signed operands.
        opa[2] = 16'h0003; opb[2] = 16'h0005;
        run_op(4'b0100, 0, 0);
        opa[1] = 16'hFFFD; opb[1] = 16'h0005;
        run_op(4'b0010, 0, 0);

        // Random masks, operands and response stalls.
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < N; i++) begin
                opa[i] = W'($urandom);
                opb[i] = W'($urandom);
            end
            run_op(N'($urandom_range(1, 15)), $urandom_range(0, 3), 0);
        end

        // Long backpressure.
        opa[3] = 16'h8000; opb[3] = 16'h7FFF;
        run_op(4'b1000, 10, 0);

        // Reset in the 10th WAIT cycle, then a fresh request with all valid.
        opa[2] = 16'h0007; opb[2] = 16'h0009;
        run_op(4'b0100, 0, 11);
        opa[0] = 16'h1234; opb[0] = 16'hFFFF;
        run_op(4'hF, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
